// File: rtl/zionriscvisalib_int_ex_arb.sv
// Two-requester round-robin arbiter in front of a shared integer execution unit,
// with a one-entry registered result stage that carries source index and tag.
module zionriscvisalib_int_ex_arb #(
  parameter int unsigned RV64  = 0,
  parameter int unsigned OP_W  = 64,
  parameter int unsigned TAG_W = 4,
  localparam int unsigned CPU_WIDTH = 32 * (RV64 + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             reqVld,
  output logic [1:0]             reqRdy,
  input  logic [2*OP_W-1:0]      reqOp,
  input  logic [2*TAG_W-1:0]     reqTag,
  input  logic                   flush,
  output logic [OP_W-1:0]        exOp,
  input  logic [CPU_WIDTH-1:0]   exRslt,
  input  logic [1:0]             exBjEn,
  input  logic [CPU_WIDTH-1:0]   exBjTgt,
  output logic                   outVld,
  input  logic                   outRdy,
  output logic                   outSrc,
  output logic [TAG_W-1:0]       outTag,
  output logic [CPU_WIDTH-1:0]   outRslt,
  output logic [1:0]             outBjEn,
  output logic [CPU_WIDTH-1:0]   outBjTgt
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic                   rr_q, rr_d;
  logic                   src_q, src_d;
  logic [TAG_W-1:0]       tag_q, tag_d;
  logic [CPU_WIDTH-1:0]   rslt_q, rslt_d;
  logic [1:0]             bjen_q, bjen_d;
  logic [CPU_WIDTH-1:0]   bjtgt_q, bjtgt_d;

  logic [1:0]             gnt;
  logic                   gnt_idx;
  logic                   can_accept;
  logic                   accept;

  // Grant, handshake, op steering and next-state for the output register.
  always_comb begin
    gnt        = 2'b00;
    gnt_idx    = 1'b0;
    can_accept = 1'b0;
    accept     = 1'b0;
    reqRdy     = 2'b00;
    exOp       = '0;
    state_d    = state_q;
    rr_d       = rr_q;
    src_d      = src_q;
    tag_d      = tag_q;
    rslt_d     = rslt_q;
    bjen_d     = bjen_q;
    bjtgt_d    = bjtgt_q;

    case (reqVld)
      2'b01:   begin gnt = 2'b01; gnt_idx = 1'b0; end
      2'b10:   begin gnt = 2'b10; gnt_idx = 1'b1; end
      2'b11:   begin gnt = rr_q ? 2'b10 : 2'b01; gnt_idx = rr_q; end
      default: begin gnt = 2'b00; gnt_idx = 1'b0; end
    endcase

    can_accept = ((state_q == EMPTY) | outRdy) & ~flush;
    accept     = can_accept & (|gnt);
    // rst_n gate keeps the handshake closed while reset is held.
    reqRdy     = {2{can_accept & rst_n}} & gnt;

    if (gnt[1])      exOp = reqOp[OP_W +: OP_W];
    else if (gnt[0]) exOp = reqOp[0 +: OP_W];

    if (accept) begin
      rr_d    = ~gnt_idx;
      src_d   = gnt_idx;
      tag_d   = gnt_idx ? reqTag[TAG_W +: TAG_W] : reqTag[0 +: TAG_W];
      rslt_d  = exRslt;
      bjen_d  = exBjEn;
      bjtgt_d = exBjTgt;
    end

    case (state_q)
      EMPTY:   if (accept) state_d = FULL;
      FULL: begin
        if (flush)       state_d = EMPTY;
        else if (accept) state_d = FULL;
        else if (outRdy) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      rr_q    <= 1'b0;
      src_q   <= 1'b0;
      tag_q   <= '0;
      rslt_q  <= '0;
      bjen_q  <= 2'b00;
      bjtgt_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      src_q   <= src_d;
      tag_q   <= tag_d;
      rslt_q  <= rslt_d;
      bjen_q  <= bjen_d;
      bjtgt_q <= bjtgt_d;
    end
  end

  assign outVld   = (state_q == FULL);
  assign outSrc   = src_q;
  assign outTag   = tag_q;
  assign outRslt  = rslt_q;
  assign outBjEn  = bjen_q;
  assign outBjTgt = bjtgt_q;

endmodule

// File: tb/tb_zionriscvisalib_int_ex_arb.sv
// Directed bench for the integer-execution arbiter: driver pushes expected results
// into a scoreboard, a monitor pops and compares on each output handshake.
module tb_zionriscvisalib_int_ex_arb;

  localparam int unsigned RV64  = 1;
  localparam int unsigned OP_W  = 64;
  localparam int unsigned TAG_W = 4;
  localparam int unsigned CW    = 64;

  localparam logic [OP_W-1:0] OP0 = 64'hA0A0_0000_1111_0001;
  localparam logic [OP_W-1:0] OP1 = 64'hB1B1_0000_2222_0002;
  localparam logic [TAG_W-1:0] TAG0 = 4'h3;
  localparam logic [TAG_W-1:0] TAG1 = 4'h9;

  typedef struct packed {
    logic             src;
    logic [TAG_W-1:0] tag;
    logic [CW-1:0]    rslt;
    logic [1:0]       bjen;
    logic [CW-1:0]    tgt;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [1:0]           reqVld;
  logic [1:0]           reqRdy;
  logic [2*OP_W-1:0]    reqOp;
  logic [2*TAG_W-1:0]   reqTag;
  logic                 flush;
  logic [OP_W-1:0]      exOp;
  logic [CW-1:0]        exRslt;
  logic [1:0]           exBjEn;
  logic [CW-1:0]        exBjTgt;
  logic                 outVld;
  logic                 outRdy;
  logic                 outSrc;
  logic [TAG_W-1:0]     outTag;
  logic [CW-1:0]        outRslt;
  logic [1:0]           outBjEn;
  logic [CW-1:0]        outBjTgt;

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t sb_q[$];
  bit   discard_pending = 1'b0;
  bit   release_pending = 1'b0;

  zionriscvisalib_int_ex_arb #(.RV64(RV64), .OP_W(OP_W), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .reqVld(reqVld), .reqRdy(reqRdy), .reqOp(reqOp),
    .reqTag(reqTag), .flush(flush), .exOp(exOp), .exRslt(exRslt), .exBjEn(exBjEn),
    .exBjTgt(exBjTgt), .outVld(outVld), .outRdy(outRdy), .outSrc(outSrc),
    .outTag(outTag), .outRslt(outRslt), .outBjEn(outBjEn), .outBjTgt(outBjTgt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
  endtask

  // One directed cycle: drive on negedge, check combinational outputs, push expectation.
  task automatic cycle(input logic [1:0] vld, input logic fl, input logic ordy,
                       input logic [CW-1:0] rslt, input logic [CW-1:0] tgt,
                       input logic [1:0] e_gnt, input logic [1:0] e_rdy, input logic e_ovld);
    logic [OP_W-1:0] e_op;
    exp_t e;
    @(negedge clk);
    if (discard_pending) begin
      if (sb_q.size() > 0) void'(sb_q.pop_front());
      discard_pending = 1'b0;
    end
    reqVld  = vld;
    flush   = fl;
    outRdy  = ordy;
    exRslt  = rslt;
    exBjEn  = rslt[1:0];
    exBjTgt = tgt;
    if (release_pending) begin
      rst_n = 1'b1;
      release_pending = 1'b0;
    end
    #1;
    e_op = e_gnt[1] ? OP1 : (e_gnt[0] ? OP0 : '0);
    check("reqRdy", 192'(reqRdy), 192'(e_rdy));
    check("outVld", 192'(outVld), 192'(e_ovld));
    check("exOp",   192'(exOp),   192'(e_op));
    if (e_rdy != 2'b00) begin
      e.src  = e_rdy[1];
      e.tag  = e_rdy[1] ? TAG1 : TAG0;
      e.rslt = rslt;
      e.bjen = rslt[1:0];
      e.tgt  = tgt;
      sb_q.push_back(e);
    end
    if (fl && e_ovld && !ordy) discard_pending = 1'b1;
  endtask

  // Monitor: every registered-valid cycle is compared against the scoreboard head.
  initial begin
    exp_t act;
    forever begin
      @(posedge clk);
      if (rst_n && outVld) begin
        act = '{src: outSrc, tag: outTag, rslt: outRslt, bjen: outBjEn, tgt: outBjTgt};
        if (sb_q.size() == 0) begin
          check("sb_underflow", 192'(act), 192'(0));
          if (act == '0) $display("FAIL sb_underflow: actual=output present required=none");
        end else begin
          check("out_payload", 192'(act), 192'(sb_q[0]));
          if (outRdy) void'(sb_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    reqVld  = 2'b11;
    reqOp   = {OP1, OP0};
    reqTag  = {TAG1, TAG0};
    flush   = 1'b0;
    outRdy  = 1'b0;
    exRslt  = 64'h55;
    exBjEn  = 2'b11;
    exBjTgt = 64'h77;
    repeat (2) @(negedge clk);
    #1;
    check("rst_outVld", 192'(outVld), 192'(0));
    check("rst_reqRdy", 192'(reqRdy), 192'(0));
    check("rst_payload", 192'({outSrc, outTag, outRslt, outBjEn, outBjTgt}), 192'(0));
    release_pending = 1'b1;

    //     vld   fl ordy rslt          tgt            gnt    rdy    ovld
    cycle(2'b01, 0, 1, 64'h1234,       64'h1000,      2'b01, 2'b01, 0);
    cycle(2'b00, 0, 1, 64'h0,          64'h0,         2'b00, 2'b00, 1);
    cycle(2'b10, 0, 1, 64'h2001,       64'h2100,      2'b10, 2'b10, 0);
    cycle(2'b11, 0, 1, 64'h3000,       64'h3100,      2'b01, 2'b01, 1);
    cycle(2'b11, 0, 1, 64'h3001,       64'h3101,      2'b10, 2'b10, 1);
    cycle(2'b11, 0, 1, 64'h3002,       64'h3102,      2'b01, 2'b01, 1);
    cycle(2'b11, 0, 1, 64'h3003,       64'h3103,      2'b10, 2'b10, 1);
    repeat (3)
      cycle(2'b11, 0, 0, 64'hDEAD,     64'hBEEF,      2'b01, 2'b00, 1);
    cycle(2'b11, 0, 1, 64'h4002,       64'h4102,      2'b01, 2'b01, 1);
    cycle(2'b10, 1, 0, 64'h5001,       64'h5101,      2'b10, 2'b00, 1);
    cycle(2'b11, 0, 0, 64'h6001,       64'h6101,      2'b10, 2'b10, 0);
    cycle(2'b11, 0, 0, 64'h6002,       64'h6102,      2'b01, 2'b00, 1);

    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_outVld", 192'(outVld), 192'(0));
    check("midrst_reqRdy", 192'(reqRdy), 192'(0));
    check("midrst_payload", 192'({outSrc, outTag, outRslt, outBjEn, outBjTgt}), 192'(0));
    sb_q.delete();
    discard_pending = 1'b0;
    release_pending = 1'b1;

    cycle(2'b01, 0, 1, 64'h7003,       64'hFFFF_0000_0000_0004, 2'b01, 2'b01, 0);
    cycle(2'b00, 0, 1, 64'h0,          64'h0,         2'b00, 2'b00, 1);
    cycle(2'b00, 0, 1, 64'h0,          64'h0,         2'b00, 2'b00, 0);

    @(negedge clk);
    if (discard_pending && sb_q.size() > 0) void'(sb_q.pop_front());
    check("sb_drained", 192'(sb_q.size()), 192'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
